// File: rtl/poly_sin_dac.sv
// poly_sin_dac: NUM_VOICES phase accumulators share one quarter-wave sine LUT; the voices are summed,
// scaled by the voice count and sent out through a delta-sigma DAC. Define DAC_2ND_ORDER_EN for a 2nd-order DAC.
module poly_sin_dac #(
   parameter int NUM_VOICES = 4,
   parameter int PHASE_W    = 30,
   parameter int SAMPLE_W   = 16,
   parameter int LUT_ADDR_W = 10
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_VOICES*PHASE_W-1:0] delta_angle,
   input  logic [NUM_VOICES-1:0]         voice_en,
   input  logic                          get_next_sample,
   output logic                          busy,
   output logic                          sample_ready,
   output logic signed [SAMPLE_W-1:0]    mix_sample,
   output logic                          overrun,
   output logic                          audio_out
);
   localparam int SH    = $clog2(NUM_VOICES);
   localparam int ACC_W = SAMPLE_W + SH;
   localparam int CNT_W = $clog2(NUM_VOICES + 1);
   localparam int LUT_D = (1 << LUT_ADDR_W) + 1;

   typedef enum logic [1:0] {IDLE, SWEEP, SCALE} state_t;

   function automatic logic [SAMPLE_W-1:0] lut_val(input int k);
      real amp;
      real ang;
      amp = $itor((1 << (SAMPLE_W - 1)) - 1);
      ang = 3.14159265358979323846 / 2.0 * $itor(k) / $itor(1 << LUT_ADDR_W);
      return SAMPLE_W'($rtoi(amp * $sin(ang) + 0.5));
   endfunction

   // Fold the quadrant onto the quarter-wave table; odd quadrants read it backwards.
   function automatic logic [LUT_ADDR_W:0] lut_index(input logic [LUT_ADDR_W+1:0] top);
      logic [LUT_ADDR_W:0] a;
      a = {1'b0, top[LUT_ADDR_W-1:0]};
      if (top[LUT_ADDR_W]) return (LUT_ADDR_W + 1)'(1 << LUT_ADDR_W) - a;
      return a;
   endfunction

   function automatic logic signed [ACC_W-1:0] signed_term(input logic [SAMPLE_W-1:0] mag,
                                                         input logic neg);
      logic signed [ACC_W-1:0] m;
      m = '0;
      m[SAMPLE_W-1:0] = mag;
      return neg ? -m : m;
   endfunction

   function automatic logic signed [SAMPLE_W-1:0] scale_mix(input logic signed [ACC_W-1:0] a);
      return SAMPLE_W'(a >>> SH);
   endfunction

   logic [SAMPLE_W-1:0] lut_rom [LUT_D];
   for (genvar k = 0; k < LUT_D; k++) begin : g_lut
      assign lut_rom[k] = lut_val(k);
   end

   state_t                        state_q, state_d;
   logic [CNT_W-1:0]              vcnt_q, vcnt_d;
   logic [PHASE_W-1:0]            phase_q [NUM_VOICES];
   logic [PHASE_W-1:0]            phase_d [NUM_VOICES];
   logic [NUM_VOICES*PHASE_W-1:0] delta_q, delta_d;
   logic [NUM_VOICES-1:0]         en_q, en_d;
   logic [SAMPLE_W-1:0]           lut_q, lut_d;
   logic                          neg_q, neg_d;
   logic                          term_vld_q, term_vld_d;
   logic signed [ACC_W-1:0]       acc_q, acc_d;
   logic signed [SAMPLE_W-1:0]    mix_q, mix_d;
   logic                          ready_q, ready_d;
   logic                          ovr_q, ovr_d;
   logic                          audio_q, audio_d;

   logic [PHASE_W-1:0]            sel_phase, sel_delta;
   logic                          sel_en;
   logic [LUT_ADDR_W+1:0]         sel_top;

   always_comb begin
      state_d    = state_q;
      vcnt_d     = vcnt_q;
      phase_d    = phase_q;
      delta_d    = delta_q;
      en_d       = en_q;
      lut_d      = lut_q;
      neg_d      = neg_q;
      term_vld_d = 1'b0;
      acc_d      = acc_q;
      mix_d      = mix_q;
      ready_d    = 1'b0;
      ovr_d      = ovr_q;
      sel_phase  = '0;
      sel_delta  = '0;
      sel_en     = 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (vcnt_q == CNT_W'(v)) begin
            sel_phase = phase_q[v];
            sel_delta = delta_q[v*PHASE_W +: PHASE_W];
            sel_en    = en_q[v];
         end
      end
      sel_top = sel_phase[PHASE_W-1 -: LUT_ADDR_W+2];

      // Registered LUT output lands here one cycle after its voice was issued.
      if (term_vld_q) acc_d = acc_q + signed_term(lut_q, neg_q);

      case (state_q)
         IDLE: begin
            if (get_next_sample) begin
               delta_d = delta_angle;
               en_d    = voice_en;
               acc_d   = '0;
               vcnt_d  = '0;
               state_d = SWEEP;
            end
         end
         SWEEP: begin
            if (vcnt_q == CNT_W'(NUM_VOICES)) begin
               state_d = SCALE;
            end else begin
               vcnt_d     = vcnt_q + CNT_W'(1);
               term_vld_d = sel_en;
               lut_d      = lut_rom[lut_index(sel_top)];
               neg_d      = sel_top[LUT_ADDR_W+1];
               for (int v = 0; v < NUM_VOICES; v++) begin
                  if (sel_en && vcnt_q == CNT_W'(v)) phase_d[v] = phase_q[v] + sel_delta;
               end
            end
         end
         SCALE: begin
            mix_d   = scale_mix(acc_q);
            ready_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (get_next_sample && state_q != IDLE) ovr_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         vcnt_q     <= '0;
         for (int v = 0; v < NUM_VOICES; v++) phase_q[v] <= '0;
         delta_q    <= '0;
         en_q       <= '0;
         lut_q      <= '0;
         neg_q      <= 1'b0;
         term_vld_q <= 1'b0;
         acc_q      <= '0;
         mix_q      <= '0;
         ready_q    <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         vcnt_q     <= vcnt_d;
         phase_q    <= phase_d;
         delta_q    <= delta_d;
         en_q       <= en_d;
         lut_q      <= lut_d;
         neg_q      <= neg_d;
         term_vld_q <= term_vld_d;
         acc_q      <= acc_d;
         mix_q      <= mix_d;
         ready_q    <= ready_d;
         ovr_q      <= ovr_d;
      end
   end

   // DAC input is the mix in offset binary.
   logic [SAMPLE_W-1:0] dac_u;
   assign dac_u = {~mix_q[SAMPLE_W-1], mix_q[SAMPLE_W-2:0]};

`ifdef DAC_2ND_ORDER_EN
   localparam int IW = SAMPLE_W + 4;
   logic signed [IW-1:0] i1_q, i1_d, i2_q, i2_d, u_ext, fb;

   always_comb begin
      u_ext = '0;
      u_ext[SAMPLE_W-1:0] = dac_u;
      fb      = audio_q ? IW'((1 << SAMPLE_W) - 1) : '0;
      i1_d    = i1_q + u_ext - fb;
      i2_d    = i2_q + i1_q - fb;
      audio_d = ~i2_q[IW-1];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         i1_q    <= '0;
         i2_q    <= '0;
         audio_q <= 1'b0;
      end else begin
         i1_q    <= i1_d;
         i2_q    <= i2_d;
         audio_q <= audio_d;
      end
   end
`else
   logic [SAMPLE_W-1:0] dacc_q, dacc_d;

   always_comb begin
      {audio_d, dacc_d} = {1'b0, dacc_q} + {1'b0, dac_u};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dacc_q  <= '0;
         audio_q <= 1'b0;
      end else begin
         dacc_q  <= dacc_d;
         audio_q <= audio_d;
      end
   end
`endif

   assign busy         = (state_q != IDLE);
   assign sample_ready = ready_q;
   assign mix_sample   = mix_q;
   assign overrun      = ovr_q;
   assign audio_out    = audio_q;
endmodule

// File: tb/tb_poly_sin_dac.sv
// Bench for poly_sin_dac: table vectors, hand sequences and random stimulus against a
// cycle-level behavioural model of the sampler and DAC.
module tb_poly_sin_dac;
   localparam int NV = 4;
   localparam int PW = 30;
   localparam int SW = 16;
   localparam int LA = 10;
   localparam longint PMASK = (64'd1 << PW) - 1;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic [NV*PW-1:0]       delta_angle = '0;
   logic [NV-1:0]          voice_en = '0;
   logic                   get_next_sample = 1'b0;
   logic                   busy, sample_ready, overrun, audio_out;
   logic signed [SW-1:0]   mix_sample;

   poly_sin_dac #(.NUM_VOICES(NV), .PHASE_W(PW), .SAMPLE_W(SW), .LUT_ADDR_W(LA)) dut (
      .clk(clk), .rst(rst), .delta_angle(delta_angle), .voice_en(voice_en),
      .get_next_sample(get_next_sample), .busy(busy), .sample_ready(sample_ready),
      .mix_sample(mix_sample), .overrun(overrun), .audio_out(audio_out)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   int     lut [0:(1<<LA)];
   longint m_phase [NV];
   int     m_mix, m_pend_mix, m_pend_cnt;
   bit     m_ready, m_ovr, m_audio;
   longint m_dacc, m_i1, m_i2;

   task automatic check(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   function automatic int m_sine(input longint p);
      int q, a, idx;
      q   = int'((p >> (PW - 2)) & 3);
      a   = int'((p >> (PW - 2 - LA)) & ((1 << LA) - 1));
      idx = (q % 2 == 1) ? (1 << LA) - a : a;
      return (q >= 2) ? -lut[idx] : lut[idx];
   endfunction

   function automatic int m_request(input logic [NV-1:0] en, input logic [NV*PW-1:0] d);
      int sum = 0;
      for (int v = 0; v < NV; v++) begin
         if (en[v]) begin
            sum += m_sine(m_phase[v]);
            m_phase[v] = (m_phase[v] + longint'(d[v*PW +: PW])) & PMASK;
         end
      end
      return sum >>> $clog2(NV);
   endfunction

   function automatic longint wrap20(input longint x);
      longint y;
      y = x & ((64'd1 << (SW + 4)) - 1);
      if (y >= (64'd1 << (SW + 3))) y -= (64'd1 << (SW + 4));
      return y;
   endfunction

   function automatic void m_dac_step(input int mix);
      longint u, s, f, n1, n2;
      u = longint'(mix) + (64'd1 << (SW - 1));
`ifdef DAC_2ND_ORDER_EN
      f  = m_audio ? (64'd1 << SW) - 1 : 0;
      n1 = wrap20(m_i1 + u - f);
      n2 = wrap20(m_i2 + m_i1 - f);
      m_audio = (m_i2 >= 0);
      m_i1 = n1;
      m_i2 = n2;
`else
      s = m_dacc + u;
      m_audio = (s >= (64'd1 << SW));
      m_dacc  = s % (64'd1 << SW);
`endif
   endfunction

   function automatic void m_reset();
      for (int v = 0; v < NV; v++) m_phase[v] = 0;
      m_mix = 0; m_pend_mix = 0; m_pend_cnt = 0;
      m_ready = 0; m_ovr = 0; m_audio = 0;
      m_dacc = 0; m_i1 = 0; m_i2 = 0;
   endfunction

   // One clock: advance the model across the edge, then compare every output.
   task automatic tick();
      bit req, accepted;
      logic [NV-1:0] en;
      logic [NV*PW-1:0] d;
      req = get_next_sample; en = voice_en; d = delta_angle;
      @(posedge clk); #1;
      if (rst) begin
         m_dac_step(m_mix);
         accepted = req && (m_pend_cnt == 0);
         if (req && m_pend_cnt != 0) m_ovr = 1;
         m_ready = 0;
         if (m_pend_cnt > 0) begin
            m_pend_cnt--;
            if (m_pend_cnt == 0) begin
               m_mix = m_pend_mix;
               m_ready = 1;
            end
         end
         if (accepted) begin
            m_pend_mix = m_request(en, d);
            m_pend_cnt = NV + 2;
         end
      end
      check("busy", busy, m_pend_cnt != 0);
      check("sample_ready", sample_ready, m_ready);
      check("mix_sample", mix_sample, m_mix);
      check("overrun", overrun, m_ovr);
      check("audio_out", audio_out, m_audio);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b0;
      get_next_sample = 1'b0;
      m_reset();
      #1;
      check("rst_busy", busy, 0);
      check("rst_ready", sample_ready, 0);
      check("rst_mix", mix_sample, 0);
      check("rst_overrun", overrun, 0);
      check("rst_audio", audio_out, 0);
      repeat (n) tick();
      rst = 1'b1;
   endtask

   task automatic request(input logic [NV-1:0] en, input logic [NV*PW-1:0] d,
                          output int got, output int lat);
      voice_en = en; delta_angle = d; get_next_sample = 1'b1;
      tick();
      get_next_sample = 1'b0;
      lat = 0; got = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (sample_ready) begin
            lat = i;
            got = mix_sample;
            break;
         end
      end
      check("latency", lat, NV + 2);
   endtask

   typedef struct {
      bit          rst_first;
      logic [NV-1:0] en;
      logic [PW-1:0] d;
      int          exp_mix;
   } vec_t;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt [8];
      int got, lat, nrdy, toggles, ones, prev, maxd, dd;
      logic prev_a;

      vt[0] = '{1'b1, 4'b0001, 30'h1000_0000, 0};
      vt[1] = '{1'b0, 4'b0001, 30'h1000_0000, 8191};
      vt[2] = '{1'b0, 4'b0001, 30'h1000_0000, 0};
      vt[3] = '{1'b0, 4'b0001, 30'h1000_0000, -8192};
      vt[4] = '{1'b1, 4'b1111, 30'h1000_0000, 0};
      vt[5] = '{1'b0, 4'b1111, 30'h1000_0000, 32767};
      vt[6] = '{1'b0, 4'b1111, 30'h1000_0000, 0};
      vt[7] = '{1'b0, 4'b1111, 30'h1000_0000, -32767};

      for (int k = 0; k <= (1 << LA); k++)
         lut[k] = $rtoi(32767.0 * $sin(3.14159265358979323846 / 2.0 * k / 1024.0) + 0.5);
      m_reset();

      #2;
      do_reset(3);

      // Single voice and all-voice quarter-turn vectors.
      for (int i = 0; i < 8; i++) begin
         if (vt[i].rst_first) do_reset(2);
         request(vt[i].en, {NV{vt[i].d}}, got, lat);
         check("mix_table", got, vt[i].exp_mix);
      end

      // Reset in the middle of a sweep.
      voice_en = 4'b1111; delta_angle = {NV{30'h0123_4567}}; get_next_sample = 1'b1;
      tick();
      get_next_sample = 1'b0;
      tick(); tick();
      do_reset(5);
      request(4'b0011, {NV{30'h0765_4321}}, got, lat);

      // Request while busy is dropped; request in the sample_ready cycle is taken.
      voice_en = 4'b0001; delta_angle = {NV{30'h0100_0000}}; get_next_sample = 1'b1;
      tick();
      get_next_sample = 1'b0;
      tick();
      get_next_sample = 1'b1;
      tick();
      get_next_sample = 1'b0;
      check("overrun_set", overrun, 1);
      nrdy = 0;
      for (int i = 0; i < NV; i++) begin
         tick();
         if (sample_ready) nrdy++;
      end
      check("single_ready", nrdy, 1);
      get_next_sample = 1'b1;
      tick();
      get_next_sample = 1'b0;
      check("accept_in_ready_cycle", busy, 1);
      repeat (NV + 3) tick();

`ifdef DAC_2ND_ORDER_EN
      do_reset(2);
      ones = 0;
      for (int i = 0; i < 1024; i++) begin
         tick();
         if (audio_out) ones++;
      end
      check("dac2_density_ok", (ones >= 511 && ones <= 513), 1);
`else
      request(4'b0000, {NV{30'h0}}, got, lat);
      check("mix_all_disabled", got, 0);
      toggles = 0;
      tick();
      prev_a = audio_out;
      for (int i = 0; i < 7; i++) begin
         tick();
         if (audio_out != prev_a) toggles++;
         prev_a = audio_out;
      end
      check("dac_alternate", toggles, 7);
`endif

      // Random traffic, including requests while busy.
      do_reset(2);
      for (int c = 0; c < 1500; c++) begin
         voice_en = NV'($urandom);
         for (int v = 0; v < NV; v++) delta_angle[v*PW +: PW] = PW'($urandom);
         get_next_sample = ($urandom_range(0, 3) == 0);
         tick();
      end
      get_next_sample = 1'b0;
      repeat (NV + 4) tick();

      // Backwards phase walk through the wrap point.
      do_reset(2);
      prev = 0; maxd = 0;
      for (int i = 0; i < 4096; i++) begin
         request(4'b0001, {NV{30'h3FFF_FFFF}}, got, lat);
         if (i > 0) begin
            dd = (got > prev) ? got - prev : prev - got;
            if (dd > maxd) maxd = dd;
         end
         prev = got;
      end
      check("wrap_step_le_13", maxd <= 13, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
